// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ byte producers share one UART transmitter.
// Hands one byte per frame to the transmitter and flags transmitters that never go busy.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*8-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_din,
  output logic               tx_flag,
  input  logic               tx_done,
  output logic               busy,
  output logic [2:0]         grant_id,
  output logic               err,
  input  logic               clr_err
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]  grant_id_q, grant_id_d;
  logic [7:0]  tx_din_q, tx_din_d;
  logic        tx_flag_q, tx_flag_d;
  logic        err_q, err_d;
  logic [7:0]  tcnt_q, tcnt_d;

  logic        found;
  logic [2:0]  gidx;
  logic [7:0]  gdata;
  logic        grant;
  logic        err_set;

  // Search upward from rr_ptr_q; the first valid requester in rotated order wins.
  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req_valid[i] && (i == (int'(rr_ptr_q) + k) % N_REQ)) begin
          found = 1'b1;
          gidx  = 3'(i);
        end
      end
    end
    gdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gidx == 3'(i)) gdata = req_data[8*i +: 8];
    end
  end

  assign grant = (state_q == IDLE) && tx_done && found && !rst;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = grant && (gidx == 3'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    tx_din_d   = tx_din_q;
    tx_flag_d  = 1'b0;
    tcnt_d     = tcnt_q;
    err_set    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d    = LAUNCH;
          tx_din_d   = gdata;
          grant_id_d = gidx;
          rr_ptr_d   = (gidx == 3'(N_REQ - 1)) ? 3'd0 : gidx + 3'd1;
          tx_flag_d  = 1'b1;
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
        tcnt_d  = '0;
      end
      WAIT_BUSY: begin
        if (!tx_done) begin
          state_d = WAIT_DONE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
          // The byte is abandoned on timeout; the requester already saw its ready.
          if (tcnt_d == 8'(BUSY_TIMEOUT)) begin
            err_set = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_d = err_set | (err_q & ~clr_err);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      tx_din_q   <= 8'hFF;
      tx_flag_q  <= 1'b0;
      err_q      <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      tx_din_q   <= tx_din_d;
      tx_flag_q  <= tx_flag_d;
      err_q      <= err_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign tx_din   = tx_din_q;
  assign tx_flag  = tx_flag_q;
  assign grant_id = grant_id_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE) && !rst;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grants, round-robin order, busy timeout and reset.
// Inputs change and outputs are sampled 1 ns after the falling clock edge.
module tb_uart_tx_arbiter;
  localparam int N_REQ        = 4;
  localparam int BUSY_TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ*8-1:0] req_data;
  logic [N_REQ-1:0] req_ready;
  logic [7:0]       tx_din;
  logic             tx_flag;
  logic             tx_done;
  logic             busy;
  logic [2:0]       grant_id;
  logic             err;
  logic             clr_err;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_arbiter #(.N_REQ(N_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_din    (tx_din),
    .tx_flag   (tx_flag),
    .tx_done   (tx_done),
    .busy      (busy),
    .grant_id  (grant_id),
    .err       (err),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts in IDLE with req_valid already driven; ends in IDLE one cycle after tx_done rises.
  task automatic transfer(input logic [3:0] exp_ready, input int exp_id, input logic [7:0] exp_byte,
                          input logic [3:0] remaining, input logic [3:0] pulse);
    #1;
    check("grant_ready", 32'(req_ready), 32'(exp_ready));
    check("idle_flag", 32'(tx_flag), 32'd0);
    @(negedge clk);
    req_valid = remaining;
    #1;
    check("launch_flag", 32'(tx_flag), 32'd1);
    check("launch_din", 32'(tx_din), 32'(exp_byte));
    check("launch_id", 32'(grant_id), 32'(exp_id));
    check("launch_ready", 32'(req_ready), 32'd0);
    check("launch_busy", 32'(busy), 32'd1);
    tx_done = 1'b0;
    @(negedge clk);
    #1;
    check("flag_one_cycle", 32'(tx_flag), 32'd0);
    @(negedge clk);
    req_valid = remaining | pulse;
    #1;
    check("wait_done_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = remaining;
    tx_done = 1'b1;
    #1;
    check("done_rise_busy", 32'(busy), 32'd1);
    check("done_rise_ready", 32'(req_ready), 32'd0);
    check("frame_din_held", 32'(tx_din), 32'(exp_byte));
    @(negedge clk);
  endtask

  // Transmitter never drops tx_done; err must appear BUSY_TIMEOUT cycles into WAIT_BUSY.
  task automatic timeout_run(input logic [3:0] valid, input logic [7:0] exp_byte, input logic clr_at_set);
    req_valid = valid;
    #1;
    check("to_ready", 32'(req_ready), 32'(valid));
    @(negedge clk);
    req_valid = '0;
    #1;
    check("to_flag", 32'(tx_flag), 32'd1);
    @(negedge clk);
    #1;
    check("to_entry_err", 32'(err), 32'd0);
    repeat (BUSY_TIMEOUT - 1) @(negedge clk);
    clr_err = clr_at_set;
    #1;
    check("to_early_err", 32'(err), 32'd0);
    check("to_early_busy", 32'(busy), 32'd1);
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    check("to_err", 32'(err), 32'd1);
    check("to_idle", 32'(busy), 32'd0);
    check("to_din", 32'(tx_din), 32'(exp_byte));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    req_data  = 32'h44A5_2211;
    tx_done   = 1'b1;
    clr_err   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_flag", 32'(tx_flag), 32'd0);
    check("rst_din", 32'(tx_din), 32'hFF);
    check("rst_id", 32'(grant_id), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;

    // Single requester 2, with a one-cycle pulse from requester 1 during WAIT_DONE.
    @(negedge clk);
    req_valid = 4'b0100;
    transfer(4'b0100, 2, 8'hA5, 4'b0000, 4'b0010);
    #1;
    check("pulse_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    check("pulse_no_flag", 32'(tx_flag), 32'd0);
    check("pulse_no_busy", 32'(busy), 32'd0);

    // rr_ptr is 3: requester 3 wins over 1, then 1.
    req_valid = 4'b1010;
    transfer(4'b1000, 3, 8'h44, 4'b0010, 4'b0000);
    transfer(4'b0010, 1, 8'h22, 4'b0000, 4'b0000);

    // Busy timeout, clear, then timeout with simultaneous clear.
    timeout_run(4'b0100, 8'hA5, 1'b0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    check("clr_err", 32'(err), 32'd0);
    timeout_run(4'b1000, 8'h44, 1'b1);

    // Reset during WAIT_DONE.
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    check("pre_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = '0;
    tx_done = 1'b0;
    #1;
    check("pre_rst_flag", 32'(tx_flag), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("in_rst_busy", 32'(busy), 32'd0);
    check("in_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'hF;
    #1;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_flag", 32'(tx_flag), 32'd0);
    check("post_rst_din", 32'(tx_din), 32'hFF);
    check("post_rst_err", 32'(err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("no_grant_tx_busy", 32'(req_ready), 32'd0);
      check("no_flag_tx_busy", 32'(tx_flag), 32'd0);
    end
    @(negedge clk);
    tx_done = 1'b1;

    // All four continuously valid: grants 0,1,2,3,0.
    transfer(4'b0001, 0, 8'h11, 4'hF, 4'b0000);
    transfer(4'b0010, 1, 8'h22, 4'hF, 4'b0000);
    transfer(4'b0100, 2, 8'hA5, 4'hF, 4'b0000);
    transfer(4'b1000, 3, 8'h44, 4'hF, 4'b0000);
    transfer(4'b0001, 0, 8'h11, 4'h0, 4'b0000);
    #1;
    check("final_err", 32'(err), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of requesters sharing one UART transmitter (legal range 2..8).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 15, meaning the maximum cycles to wait for tx_done to fall after tx_flag (legal range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, N_REQ bits: per-requester byte available.
REQ-006 SHALL have port req_data, input, N_REQ*8 bits: requester i byte at bits [8i+7:8i].
REQ-007 SHALL have port req_ready, output, N_REQ bits: per-requester byte accepted this cycle.
REQ-008 SHALL have port tx_din, output, 8 bits: byte to the transmitter.
REQ-009 SHALL have port tx_flag, output, 1 bit: transmit-start pulse to the transmitter.
REQ-010 SHALL have port tx_done, input, 1 bit: transmitter idle (high = idle).
REQ-011 SHALL have port busy, output, 1 bit: arbiter not in IDLE.
REQ-012 SHALL have port grant_id, output, 3 bits: index of the last granted requester.
REQ-013 SHALL have port err, output, 1 bit: sticky flag for a busy-timeout.
REQ-014 SHALL have port clr_err, input, 1 bit: clears err.

Function
REQ-015 SHALL implement the states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-016 In IDLE with tx_done=1 and any req_valid set, SHALL select requester g by round-robin.
REQ-017 Round-robin SHALL search upward from pointer rr_ptr, modulo N_REQ.
REQ-018 SHALL assert req_ready[g] combinationally in that same cycle, at most one bit set.
REQ-019 At that edge SHALL latch req_data[g] into tx_din, set grant_id=g, set rr_ptr=(g+1) mod N_REQ, and go to LAUNCH.
REQ-020 In IDLE with tx_done=0 or no req_valid, SHALL keep req_ready all zero and remain in IDLE.
REQ-021 In LAUNCH, SHALL drive tx_flag=1 for exactly one cycle, then go to WAIT_BUSY.
REQ-022 SHALL drive tx_flag=0 in every state other than LAUNCH.
REQ-023 In WAIT_BUSY with tx_done=0, SHALL go to WAIT_DONE.
REQ-024 In WAIT_BUSY with tx_done=1, SHALL increment timeout counter tcnt (8-bit, zeroed on entry).
REQ-025 When tcnt reaches BUSY_TIMEOUT, SHALL set err=1 and go to IDLE; the byte is dropped and not retried.
REQ-026 In WAIT_DONE, SHALL go to IDLE when tx_done=1; there is no timeout in this state.
REQ-027 tx_din SHALL hold the latched byte from LAUNCH until the next grant, so the transmitter may sample it at any time during the frame.
REQ-028 req_ready SHALL be zero in every state except IDLE.
REQ-029 busy SHALL be 1 exactly when the state is not IDLE.
REQ-030 Latency SHALL be: grant in cycle t, tx_flag in cycle t+1, and earliest next grant in the cycle after tx_done returns high in WAIT_DONE.
REQ-031 Requesters whose req_valid drops before being granted SHALL be skipped without side effects.
REQ-032 err SHALL clear on clr_err=1; a simultaneous set and clear SHALL leave err=1.
REQ-033 A requester's byte count is not limited; a continuously valid single requester SHALL be granted once per frame.

Reset
REQ-034 rst=1 SHALL at the next edge force state=IDLE, rr_ptr=0, grant_id=0, tx_din=8'hFF, tx_flag=0, err=0, tcnt=0, overriding any in-progress operation.
REQ-035 During rst=1, req_ready SHALL be all zero and busy SHALL be 0.
REQ-036 Reset mid-frame SHALL not assert tx_flag again; after reset the arbiter SHALL wait for tx_done=1 before granting.

Verification
REQ-037 Scenario: only req_valid[2] set with data 8'hA5, tx_done=1 -> req_ready=4'b0100 in cycle t, tx_flag=1 in t+1 with tx_din=8'hA5, grant_id=2.
REQ-038 Scenario: all four valid continuously with a transmitter model -> grants issued in order 0,1,2,3,0, each only after tx_done rises.
REQ-039 Scenario: rr_ptr=3 after a grant to 2, requesters 1 and 3 valid -> requester 3 granted, then requester 1.
REQ-040 Scenario: tx_done held at 1 after tx_flag -> err=1 exactly BUSY_TIMEOUT cycles after entering WAIT_BUSY, state back to IDLE; clr_err together with a new timeout leaves err=1.
REQ-041 Scenario: rst=1 pulsed during WAIT_DONE -> next cycle busy=0, tx_flag=0, tx_din=8'hFF, err=0; no grant while tx_done=0.
REQ-042 Scenario: req_valid[1] pulsed for one cycle while in WAIT_DONE -> no req_ready[1] and no transmission for that request.
